// File: rtl/zx_io_ula.sv
// zx_io_ula: Spectrum-style I/O ULA on the Z80 bus: port #FE border/MIC/beeper latch, keyboard + EAR read, frame nINT.
// Optional macro ZX_ISSUE2_EN: the MIC output bit leaks into the EAR read bit, as on issue-2 boards.
module zx_io_ula #(
   parameter int FRAME_TSTATES = 69888,
   parameter int INT_LEN       = 32,
   parameter int EAR_SYNC      = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] a,
   input  logic [7:0]  d_in,
   input  logic        n_iorq,
   input  logic        n_rd,
   input  logic        n_wr,
   input  logic        n_m1,
   input  logic        mic,
   input  logic [39:0] keys,
   output logic [7:0]  d_out,
   output logic        d_oe,
   output logic        n_int,
   output logic [2:0]  border,
   output logic        mic_out,
   output logic        beeper,
   output logic        frame
);
   localparam int TW = $clog2(FRAME_TSTATES);
   localparam logic [TW-1:0] TLAST = TW'(FRAME_TSTATES - 1);
   localparam logic [TW-1:0] TINT  = TW'(INT_LEN);

   logic [TW-1:0]       tcntReg, tcntNext;
   logic                nIntReg;
   logic [EAR_SYNC-1:0] earReg;
   logic                wrActiveReg;
   logic [2:0]          borderReg;
   logic                micOutReg, beeperReg;
   logic                sel, wrActive, wrEdge, earBit;
   logic [8:0][4:0]     rowAnd;
   logic                unusedBits;

   // An interrupt acknowledge also drops nIORQ, but with nM1 low; never treat it as a port cycle.
   assign sel      = ~n_iorq & n_m1 & ~a[0];
   assign wrActive = sel & ~n_wr;
   assign wrEdge   = wrActive & ~wrActiveReg;
   assign unusedBits = ^{a[7:1], d_in[7:5]};

   assign tcntNext = (tcntReg == TLAST) ? '0 : tcntReg + TW'(1);

   always_ff @(posedge clock) begin
      if (reset) begin
         tcntReg     <= '0;
         nIntReg     <= 1'b1;
         earReg      <= '0;
         wrActiveReg <= 1'b0;
         borderReg   <= 3'b000;
         micOutReg   <= 1'b0;
         beeperReg   <= 1'b0;
      end else begin
         tcntReg     <= tcntNext;
         nIntReg     <= (tcntReg >= TINT);
         earReg      <= {earReg[EAR_SYNC-2:0], mic};
         wrActiveReg <= wrActive;
         // Latch only on the first clock of a write cycle, however long nWR is held.
         if (wrEdge) begin
            borderReg <= d_in[2:0];
            micOutReg <= d_in[3];
            beeperReg <= d_in[4];
         end
      end
   end

   // Half-row select: each low address line A8..A15 ANDs its key row into the column bits.
   assign rowAnd[0] = 5'b11111;
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_row
         assign rowAnd[gi+1] = a[8+gi] ? rowAnd[gi] : (rowAnd[gi] & keys[5*gi +: 5]);
      end
   endgenerate

`ifdef ZX_ISSUE2_EN
   assign earBit = earReg[EAR_SYNC-1] | micOutReg;
`else
   assign earBit = earReg[EAR_SYNC-1];
`endif

   assign d_oe = sel & ~n_rd;

   always_comb begin
      d_out = 8'hFF;
      if (d_oe) begin
         d_out = {1'b1, earBit, 1'b1, rowAnd[8]};
      end
   end

   assign n_int   = nIntReg;
   assign frame   = (tcntReg == TLAST);
   assign border  = borderReg;
   assign mic_out = micOutReg;
   assign beeper  = beeperReg;
endmodule

// File: tb/tb_zx_io_ula.sv
// tb_zx_io_ula: directed + randomized bench for zx_io_ula against a cycle-indexed behavioural model.
module tb_zx_io_ula;
   localparam int F  = 69888;
   localparam int IL = 32;
   localparam int ES = 2;
`ifdef ZX_ISSUE2_EN
   localparam bit ISSUE2 = 1'b1;
`else
   localparam bit ISSUE2 = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] a = 16'hFFFF;
   logic [7:0]  d_in = 8'h00;
   logic        n_iorq = 1'b1, n_rd = 1'b1, n_wr = 1'b1, n_m1 = 1'b1, mic = 1'b0;
   logic [39:0] keys = '1;
   logic [7:0]  d_out;
   logic        d_oe, n_int, mic_out, beeper, frame;
   logic [2:0]  border;

   zx_io_ula #(.FRAME_TSTATES(F), .INT_LEN(IL), .EAR_SYNC(ES)) dut (
      .clock(clock), .reset(reset), .a(a), .d_in(d_in), .n_iorq(n_iorq), .n_rd(n_rd),
      .n_wr(n_wr), .n_m1(n_m1), .mic(mic), .keys(keys), .d_out(d_out), .d_oe(d_oe),
      .n_int(n_int), .border(border), .mic_out(mic_out), .beeper(beeper), .frame(frame)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int timerErrs = 0;

   // Model: cycle index since reset, and the mic value seen at every clock edge.
   int cyc = 0;
   bit micLog [131072];
   logic [2:0] expBorder = 3'b000;
   logic       expMic = 1'b0, expBeep = 1'b0;

   always @(posedge clock) begin
      if (reset) cyc <= 0;
      else begin
         cyc <= cyc + 1;
         micLog[cyc + 1] <= mic;
      end
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic expNInt(input int n);
      return (n == 0) ? 1'b1 : (((n - 1) % F) >= IL);
   endfunction

   function automatic logic expEar(input int n);
      return (n - ES + 1 >= 1) ? logic'(micLog[n - ES + 1]) : 1'b0;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      if (n_int !== expNInt(cyc) || frame !== ((cyc % F) == F - 1)) timerErrs++;
   endtask

   function automatic logic [7:0] expRead(input logic [15:0] addr, input logic m1, input logic [39:0] k);
      logic [4:0] cols = 5'b11111;
      if (addr[0] || !m1) return 8'hFF;
      for (int r = 0; r < 8; r++)
         if (!addr[8+r]) cols = cols & k[5*r +: 5];
      return {1'b1, expEar(cyc) | (ISSUE2 & expMic), 1'b1, cols};
   endfunction

   task automatic doWrite(input logic [15:0] addr, input logic m1, input logic [7:0] data, input int hold);
      a = addr; n_m1 = m1; d_in = data; n_iorq = 1'b0; n_wr = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         if (i == 0) begin
            if (!addr[0] && m1) begin
               expBorder = data[2:0]; expMic = data[3]; expBeep = data[4];
            end
            checkVal("wr_first_border", border, expBorder);
         end
         d_in = 8'($urandom);
      end
      n_iorq = 1'b1; n_wr = 1'b1; n_m1 = 1'b1;
      step();
      checkVal("wr_border", border, expBorder);
      checkVal("wr_mic", mic_out, expMic);
      checkVal("wr_beeper", beeper, expBeep);
   endtask

   task automatic doRead(input logic [15:0] addr, input logic m1, input logic [39:0] k);
      a = addr; n_m1 = m1; keys = k; n_iorq = 1'b0; n_rd = 1'b0;
      #1;
      checkVal("rd_oe", d_oe, !addr[0] && m1);
      checkVal("rd_data", d_out, expRead(addr, m1, k));
      step();
      n_iorq = 1'b1; n_rd = 1'b1; n_m1 = 1'b1;
   endtask

   initial begin
      int firstLow = -1, lowCnt = 0, frameAt = -1, framePulses = 0, secondFall = -1;
      logic prevN = 1'b1;

      // Reset
      repeat (3) step();
      checkVal("rst_border", border, 3'b000);
      checkVal("rst_beeper", beeper, 1'b0);
      checkVal("rst_mic", mic_out, 1'b0);
      checkVal("rst_nint", n_int, 1'b1);
      checkVal("rst_frame", frame, 1'b0);
      checkVal("rst_oe", d_oe, 1'b0);
      checkVal("rst_dout", d_out, 8'hFF);

      // Full frame from reset release
      reset = 1'b0;
      for (int i = 0; i < F + 40; i++) begin
         step();
         if (!n_int) begin
            if (firstLow < 0) firstLow = cyc;
            if (cyc <= F) lowCnt++;
         end
         if (frame) begin framePulses++; frameAt = cyc; end
         if (prevN && !n_int && cyc > IL + 1 && secondFall < 0) secondFall = cyc;
         prevN = n_int;
      end
      checkVal("frame_first_low", firstLow, 1);
      checkVal("frame_low_len", lowCnt, IL);
      checkVal("frame_pulse_at", frameAt, F - 1);
      checkVal("frame_pulse_cnt", framePulses, 1);
      checkVal("frame_second_fall", secondFall, F + 1);

      // OUT (#FE),#17 held 3 clocks, then #00
      doWrite(16'h00FE, 1'b1, 8'h17, 3);
      checkVal("out17_border", border, 3'b111);
      checkVal("out17_beeper", beeper, 1'b1);
      checkVal("out17_mic", mic_out, 1'b0);
      doWrite(16'h12FE, 1'b1, 8'h00, 2);
      checkVal("out00_all", {border, beeper, mic_out}, 5'b0);

      // Keyboard half-row + EAR
      mic = 1'b1;
      repeat (ES + 1) step();
      a = 16'hFDFE; n_iorq = 1'b0; n_rd = 1'b0; keys = ~(40'd1 << 5);
      #1;
      checkVal("rd_fdfe_oe", d_oe, 1'b1);
      checkVal("rd_fdfe_ear1", d_out, 8'hFE);
      n_iorq = 1'b1; n_rd = 1'b1;
      mic = 1'b0;
      repeat (ES + 1) step();
      a = 16'hFDFE; n_iorq = 1'b0; n_rd = 1'b0;
      #1;
      checkVal("rd_fdfe_ear0", d_out, 8'hBE);
      keys = ~((40'd1 << 2) | (40'd1 << 39));
      a = 16'h00FE;
      #1;
      checkVal("rd_allrows", d_out[4:0], 5'b01011);
      a = 16'h00FF;
      #1;
      checkVal("rd_odd_oe", d_oe, 1'b0);
      checkVal("rd_odd_dout", d_out, 8'hFF);
      n_m1 = 1'b0; a = 16'h00FE;
      #1;
      checkVal("rd_intack_oe", d_oe, 1'b0);
      n_iorq = 1'b1; n_rd = 1'b1; n_m1 = 1'b1;
      step();

      // MIC leakage into bit 6
      doWrite(16'h00FE, 1'b1, 8'h08, 1);
      a = 16'h00FE; n_iorq = 1'b0; n_rd = 1'b0;
      #1;
      checkVal("issue2_bit6", d_out[6], ISSUE2);
      n_iorq = 1'b1; n_rd = 1'b1;
      step();

      // Randomized bus traffic
      for (int t = 0; t < 300; t++) begin
         logic [15:0] addr = 16'($urandom);
         logic        m1 = ($urandom_range(0, 3) != 0);
         mic = 1'($urandom);
         case ($urandom_range(0, 2))
            0: doWrite(addr, m1, 8'($urandom), $urandom_range(1, 4));
            1: doRead(addr, m1, {8'($urandom), 32'($urandom)});
            default: step();
         endcase
      end

      // Reset beats a simultaneous write
      reset = 1'b1; a = 16'h00FE; d_in = 8'hFF; n_iorq = 1'b0; n_wr = 1'b0;
      step();
      expBorder = 3'b000; expMic = 1'b0; expBeep = 1'b0;
      checkVal("rst_vs_wr_border", border, 3'b000);
      checkVal("rst_vs_wr_beeper", beeper, 1'b0);
      checkVal("rst_vs_wr_nint", n_int, 1'b1);
      n_iorq = 1'b1; n_wr = 1'b1;
      reset = 1'b0;
      repeat (4) step();
      checkVal("timer_trace_errs", timerErrs, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
